seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NCH, default 8, meaning number of display channels (2..16).
REQ-002 The block SHALL have parameter DW, default 32, meaning data bits per channel (multiple of 4, 4..64); digits per channel ND = DW/4.
REQ-003 The block SHALL have parameter DIV, default 1, meaning clk cycles per scan step (1..65535).
REQ-004 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port en  input  1  scan enable; low freezes prescaler and all outputs.
REQ-007 The block SHALL have port data_in  input  NCH*DW  channel values, channel 0 in the most significant DW bits.
REQ-008 The block SHALL have port freeze  input  1  high inhibits snapshot update at frame start.
REQ-009 The block SHALL have port blank  input  NCH  per-channel blank mask, bit k blanks channel k.
REQ-010 The block SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-011 The block SHALL have port SEG_OUT  output  8*ND  segment pattern, 8 bits per digit, most significant digit in the top byte.
REQ-012 The block SHALL have port SEG_SEL  output  NCH  one-hot channel select, bit k = channel k.
REQ-013 The block SHALL have port frame_start  output  1  one-cycle pulse when SEG_SEL moves to channel 0.

Function
REQ-014 Prescaler SHALL count 0..DIV-1 while en=1; tick = (count==DIV-1) & en; count wraps to 0 on tick; holds when en=0.
REQ-015 On tick, SEG_SEL SHALL advance: 0 -> bit0; bit k -> bit k+1; bit NCH-1 -> bit0 (wrap).
REQ-016 SEG_SEL SHALL never hold more than one set bit; any illegal value SHALL recover to bit0 on the next tick.
REQ-017 On the tick moving SEG_SEL to bit0, snapshot registers SHALL load data_in unless freeze=1, and frame_start SHALL be 1 for exactly that following cycle.
REQ-018 SEG_OUT SHALL be registered and update on the same edge as SEG_SEL, always showing the decode of the newly selected channel (zero added latency between select and data).
REQ-019 For the bit0 step, SEG_OUT SHALL decode data_in directly when the snapshot is loading that edge, otherwise the held snapshot.
REQ-020 Nibble decode SHALL be 0:FC 1:60 2:DA 3:F2 4:66 5:B6 6:BE 7:E0 8:FE 9:F6 A:EE B:3E C:1A D:7A E:9E F:8E (hex).
REQ-021 If blank[k]=1 at the tick selecting channel k, SEG_OUT SHALL be all zeros for that step.
REQ-022 With lz_en=1, every digit above the highest nonzero nibble SHALL output 8'h00; value 0 SHALL show FC in the least significant digit only.
REQ-023 blank and lz_en SHALL be sampled only at ticks; changes between ticks SHALL not alter SEG_OUT.
REQ-024 With DIV=1, tick SHALL occur every en=1 cycle.
REQ-025 en falling mid-step SHALL hold count, SEG_SEL, SEG_OUT; en rising SHALL resume from the held count.

Reset
REQ-026 rst=1 SHALL immediately clear SEG_SEL, SEG_OUT, frame_start, prescaler count and snapshot to 0, regardless of clk.
REQ-027 Reset asserted mid-frame SHALL discard the frame; after release the first tick SHALL select bit0 with frame_start and a fresh snapshot.

Verification
REQ-028 NCH=8, DIV=1, en=1, release rst -> SEG_SEL 01,02,04,...,80,01 on successive cycles; frame_start high only in cycles with SEG_SEL=01.
REQ-029 ch0=0x0123ABCD, lz_en=0 -> while SEG_SEL=01, SEG_OUT=FC60DAF2EE3E1A7A.
REQ-030 lz_en=1, ch1=0x000000A5 -> SEG_OUT=000000000000EEB6; ch2=0 -> 00000000000000FC; blank[3]=1 -> channel 3 shows 0.
REQ-031 DIV=4 -> SEG_SEL changes every 4th cycle; en low 3 cycles mid-step extends that step to 7 cycles.
REQ-032 freeze=1 then change ch0 to 0xFFFFFFFF -> next frames still show old ch0; freeze=0 -> new value appears at next frame_start.
REQ-033 rst pulse while SEG_SEL=10 -> all outputs 0 asynchronously; after release next tick SEG_SEL=01 with frame_start=1.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller with snapshot, blanking and leading-zero suppression
module seg_scan_ctrl #(
  parameter int NCH = 8,
  parameter int DW  = 32,
  parameter int DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NCH*DW-1:0]     data_in,
  input  logic                  freeze,
  input  logic [NCH-1:0]        blank,
  input  logic                  lz_en,
  output logic [8*(DW/4)-1:0]   SEG_OUT,
  output logic [NCH-1:0]        SEG_SEL,
  output logic                  frame_start
);

  localparam int ND = DW / 4;
  localparam int CW = 16;
  localparam int IW = $clog2(NCH);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tick;
  logic [NCH-1:0]    sel_q, sel_d;
  logic [8*ND-1:0]   seg_q, seg_d;
  logic              fs_q, fs_d;
  logic [DW-1:0]     snap_q [NCH];

  logic [IW:0]       ones_c;
  logic [IW-1:0]     cur_idx, nxt_idx;
  logic              wrap;
  logic              load;
  logic [DW-1:0]     val_c;
  logic [8*ND-1:0]   seg_c;

  assign SEG_OUT     = seg_q;
  assign SEG_SEL     = sel_q;
  assign frame_start = fs_q;

  // Nibble to segment pattern, segment a in bit 7 down to dp in bit 0.
  function automatic logic [7:0] seg_lut(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'h0: p = 8'hFC;
      4'h1: p = 8'h60;
      4'h2: p = 8'hDA;
      4'h3: p = 8'hF2;
      4'h4: p = 8'h66;
      4'h5: p = 8'hB6;
      4'h6: p = 8'hBE;
      4'h7: p = 8'hE0;
      4'h8: p = 8'hFE;
      4'h9: p = 8'hF6;
      4'hA: p = 8'hEE;
      4'hB: p = 8'h3E;
      4'hC: p = 8'h1A;
      4'hD: p = 8'h7A;
      4'hE: p = 8'h9E;
      default: p = 8'h8E;
    endcase
    return p;
  endfunction

  // Prescaler: one scan step every DIV enabled cycles; frozen while en is low.
  always_comb begin
    tick  = en && (cnt_q == CW'(DIV - 1));
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Locate the current channel; anything not exactly one-hot restarts the scan at channel 0.
  always_comb begin
    ones_c  = '0;
    cur_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_q[k]) begin
        ones_c  = ones_c + (IW+1)'(1);
        cur_idx = IW'(k);
      end
    end
    wrap    = (ones_c != (IW+1)'(1)) || sel_q[NCH-1];
    nxt_idx = wrap ? '0 : cur_idx + IW'(1);
  end

  // Next select, frame pulse and snapshot load decision for this edge.
  always_comb begin
    sel_d = tick ? (NCH'(1) << nxt_idx) : sel_q;
    fs_d  = tick && wrap;
    load  = tick && wrap && !freeze;
  end

  // Pick the value of the channel being selected; bypass the snapshot on the edge it loads.
  always_comb begin
    if (load) begin
      val_c = data_in[(NCH-1)*DW +: DW];
    end else begin
      val_c = snap_q[nxt_idx];
    end
  end

  // Decode all digits, honouring blanking and leading-zero suppression (the last digit always shows).
  always_comb begin
    logic seen;
    logic [3:0] nib;
    seen  = 1'b0;
    nib   = '0;
    seg_c = '0;
    if (!blank[nxt_idx]) begin
      for (int d = ND - 1; d >= 0; d--) begin
        nib = val_c[4*d +: 4];
        if (nib != 4'h0) begin
          seen = 1'b1;
        end
        if (lz_en && !seen && (d != 0)) begin
          seg_c[8*d +: 8] = 8'h00;
        end else begin
          seg_c[8*d +: 8] = seg_lut(nib);
        end
      end
    end
    seg_d = tick ? seg_c : seg_q;
  end

  // Prescaler, select, segment and frame-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sel_q <= '0;
      seg_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
      fs_q  <= fs_d;
    end
  end

  // Frame snapshot, refreshed only on the step that returns to channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        snap_q[k] <= '0;
      end
    end else if (load) begin
      for (int k = 0; k < NCH; k++) begin
        snap_q[k] <= data_in[(NCH-1-k)*DW +: DW];
      end
    end
  end

endmodule
